// File: rtl/count_checker.sv
// count_checker: locks onto a +1 count stream and flags/counts skips, stalls and natural wraps
module count_checker #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 count_rst,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_WIDTH-1:0] err_count,
  output logic                 wrap_pulse,
  output logic [CNT_WIDTH-1:0] wrap_count
);
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_WIDTH-1:0] SAT = '1;
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;
  state_t state, state_d;
  logic [GW-1:0] good_cnt, good_d;
  logic [WIDTH-1:0] prev_v, expected;
  logic prev_rst, match, err_d, wrap_d;
  logic [CNT_WIDTH-1:0] err_cnt_d, wrap_cnt_d;
  assign locked = state == LOCKED;
  always_comb begin
    expected = prev_rst ? '0 : prev_v + 1'b1;
    match = count_in == expected;
    state_d = state;
    good_d = good_cnt;
    if (clear || state == IDLE || !match) begin
      state_d = clear ? IDLE : ACQUIRE;
      good_d = '0;
    end else if (state == ACQUIRE) begin
      good_d = good_cnt + 1'b1;
      state_d = (good_d == GW'(LOCK_COUNT)) ? LOCKED : ACQUIRE;
    end
    // a zero forced by the counter's own reset is never a wrap
    err_d = !clear && state == LOCKED && !match;
    wrap_d = !clear && state != IDLE && prev_v == '1 && !prev_rst && count_in == '0;
    err_cnt_d = clear ? '0 : (err_d && err_count != SAT) ? err_count + 1'b1 : err_count;
    wrap_cnt_d = clear ? '0 : (wrap_d && wrap_count != SAT) ? wrap_count + 1'b1 : wrap_count;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      good_cnt   <= '0;
      prev_v     <= '0;
      prev_rst   <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      state      <= state_d;
      good_cnt   <= good_d;
      prev_v     <= count_in;
      prev_rst   <= count_rst;
      err_pulse  <= err_d;
      wrap_pulse <= wrap_d;
      err_count  <= err_cnt_d;
      wrap_count <= wrap_cnt_d;
    end
  end
endmodule
